instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: REQ/WAIT/HOLD handshake with imem,
// one-entry skid buffer behind a registered decode-facing output stage.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        hazard_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [11:0] pc_offset_o
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, inflight_pc;
    logic        discard, discard_n;
    fetch_t      skid;
    logic        consumed, fire, load_rsp, unpark, park;
    logic        vld_n;
    logic [31:0] pc_n, instr_n;

    function automatic logic [11:0] branch_off(input logic [31:0] i);
        return {i[31], i[7], i[30:25], i[11:8]};
    endfunction

    assign consumed    = valid_o & ~hazard_i;
    assign imem_req_o  = (state == S_REQ);
    assign imem_addr_o = fetch_pc;

    always_comb begin
        state_n   = state;
        discard_n = discard;
        fire      = 1'b0;
        load_rsp  = 1'b0;
        unpark    = 1'b0;
        park      = 1'b0;
        case (state)
            S_REQ: if (imem_gnt_i) begin
                fire    = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: if (imem_rvalid_i) begin
                discard_n = 1'b0;
                state_n   = S_REQ;
                if (!discard) begin
                    if (!valid_o || consumed) load_rsp = 1'b1;
                    else begin
                        park    = 1'b1;
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: if (consumed) begin
                unpark  = 1'b1;
                state_n = S_REQ;
            end
            default: state_n = S_REQ;
        endcase
        if (flush_i) begin
            // a response is still owed to memory: wait it out before re-requesting
            discard_n = (state == S_WAIT && !imem_rvalid_i) || (state == S_REQ && imem_gnt_i);
            state_n   = discard_n ? S_WAIT : S_REQ;
            load_rsp  = 1'b0;
            unpark    = 1'b0;
            park      = 1'b0;
        end
    end

    always_comb begin
        vld_n   = valid_o;
        pc_n    = pc_o;
        instr_n = instr_o;
        if (flush_i || (consumed && !load_rsp && !unpark)) begin
            vld_n   = 1'b0;
            pc_n    = '0;
            instr_n = '0;
        end else if (load_rsp) begin
            vld_n   = 1'b1;
            pc_n    = inflight_pc;
            instr_n = imem_rdata_i;
        end else if (unpark) begin
            vld_n   = 1'b1;
            pc_n    = skid.pc;
            instr_n = skid.instr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            discard     <= 1'b0;
            skid        <= '0;
            valid_o     <= 1'b0;
            pc_o        <= '0;
            instr_o     <= '0;
            pc_offset_o <= '0;
        end else begin
            state       <= state_n;
            discard     <= discard_n;
            valid_o     <= vld_n;
            pc_o        <= pc_n;
            instr_o     <= instr_n;
            pc_offset_o <= branch_off(instr_n);
            if (fire) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (park) skid <= '{pc: inflight_pc, instr: imem_rdata_i};
            if (flush_i) begin
                fetch_pc <= {flush_pc_i[31:2], 2'b00};
                skid     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a transaction-level model
// (queue of owed instructions, outstanding-request flag, next fetch address).
module tb_instr_fetch_unit;
    logic        CLK;
    logic        RESET;
    logic        imem_gnt_i, imem_rvalid_i, hazard_i, flush_i;
    logic [31:0] imem_rdata_i, flush_pc_i;
    logic        imem_req_o, valid_o, imem_req2, valid2;
    logic [31:0] imem_addr_o, pc_o, instr_o, imem_addr2, pc2, instr2;
    logic [11:0] pc_offset_o, pc_offset2;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit u_dut (
        .CLK(CLK), .RESET(RESET),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .hazard_i(hazard_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o), .pc_offset_o(pc_offset_o)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(CLK), .RESET(RESET),
        .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .hazard_i(hazard_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .valid_o(valid2), .pc_o(pc2), .instr_o(instr2), .pc_offset_o(pc_offset2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h8) return 32'hFE00_0EE3;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [11:0] boff(input logic [31:0] i);
        return {i[31], i[7], i[30:25], i[11:8]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        q[$];
    logic        pend, pend_ok, mdl_ok;
    logic [31:0] pend_addr, nextpc, nextpc2;
    ent_t        e;

    initial begin
        mdl_ok = 1'b0;
        pend   = 1'b0;
    end

    always @(posedge CLK) begin
        if (RESET) begin
            q.delete();
            pend    = 1'b0;
            pend_ok = 1'b0;
            nextpc  = 32'h0;
            nextpc2 = 32'hFFFF_FFFC;
            mdl_ok  = 1'b1;
        end else if (mdl_ok) begin
            if (q.size() > 0 && !hazard_i) void'(q.pop_front());
            if (imem_rvalid_i && pend) begin
                if (pend_ok && !flush_i) begin
                    e.pc  = pend_addr;
                    e.ins = imem_rdata_i;
                    q.push_back(e);
                end
                pend = 1'b0;
            end
            if (imem_req_o && imem_gnt_i) begin
                pend      = 1'b1;
                pend_ok   = 1'b1;
                pend_addr = imem_addr_o;
                nextpc    = nextpc + 32'd4;
                nextpc2   = nextpc2 + 32'd4;
            end
            if (flush_i) begin
                q.delete();
                pend_ok = 1'b0;
                nextpc  = {flush_pc_i[31:2], 2'b00};
                nextpc2 = nextpc;
            end
        end
    end

    always @(negedge CLK) begin
        if (mdl_ok) begin
            chk("valid", valid_o, q.size() > 0);
            if (q.size() > 0) begin
                chk("pc", pc_o, q[0].pc);
                chk("instr", instr_o, q[0].ins);
                chk("offset", pc_offset_o, boff(q[0].ins));
            end else begin
                chk("instr_idle", instr_o, 32'h0);
                chk("offset_idle", pc_offset_o, 12'h0);
            end
            chk("req", imem_req_o, !pend && q.size() < 2);
            if (imem_req_o) chk("addr", imem_addr_o, nextpc);
            chk("req2", imem_req2, imem_req_o);
            chk("valid2", valid2, valid_o);
            chk("instr2", instr2, instr_o);
            if (imem_req2) chk("addr2", imem_addr2, nextpc2);
        end
    end

    // ---------------- responder / driver ----------------
    logic        gnt_en, rv_en, outst;
    logic [31:0] out_addr;

    task automatic tick(input logic hz = 1'b0, input logic fl = 1'b0, input logic [31:0] fpc = 32'h0);
        logic [31:0] a;
        hazard_i      = hz;
        flush_i       = fl;
        flush_pc_i    = fpc;
        imem_gnt_i    = imem_req_o && gnt_en;
        imem_rvalid_i = outst && rv_en;
        imem_rdata_i  = imem_rvalid_i ? mem(out_addr) : 32'hDEAD_BEEF;
        a = imem_addr_o;
        @(posedge CLK);
        if (imem_rvalid_i) outst = 1'b0;
        if (imem_gnt_i) begin
            outst    = 1'b1;
            out_addr = a;
        end
        if (RESET) outst = 1'b0;
        #1;
    endtask

    initial begin
        RESET = 1'b1; gnt_en = 1'b0; rv_en = 1'b1; outst = 1'b0; out_addr = '0;
        hazard_i = 0; flush_i = 0; flush_pc_i = '0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
        tick(); tick();
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_off", pc_offset_o, 12'h0);
        chk("rst_req", imem_req_o, 1'b1);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

        // streaming, one instruction every two cycles
        RESET = 1'b0; gnt_en = 1'b1;
        tick(); tick();
        chk("s0_pc", pc_o, 32'h0);
        chk("s0_instr", instr_o, 32'hBEEF_0000);
        chk("wrap_addr2", imem_addr2, 32'h0000_0000);
        tick();
        chk("s_gap_valid", valid_o, 1'b0);
        tick();
        chk("s1_pc", pc_o, 32'h4);
        chk("s1_instr", instr_o, 32'hBEEB_0004);
        tick(); tick();
        chk("s2_instr", instr_o, 32'hFE00_0EE3);

        // hazard while the next response lands in the skid buffer
        tick(1); tick(1);
        chk("hz_req", imem_req_o, 1'b0);
        tick(1);
        chk("hz_instr", instr_o, 32'hFE00_0EE3);
        chk("hz_off", pc_offset_o, 12'hFFE);
        chk("hz_pc", pc_o, 32'h8);
        chk("hz_req2", imem_req_o, 1'b0);
        tick(0);
        chk("hz_next_pc", pc_o, 32'hC);
        chk("hz_next_instr", instr_o, 32'hBEE3_000C);

        // flush in WAIT, stale response returns later
        tick();
        rv_en = 1'b0;
        tick(0, 1, 32'h0000_0103);
        chk("fl_valid", valid_o, 1'b0);
        chk("fl_req_wait", imem_req_o, 1'b0);
        rv_en = 1'b1;
        tick();
        chk("fl_req", imem_req_o, 1'b1);
        chk("fl_addr", imem_addr_o, 32'h0000_0100);
        tick(); tick();
        chk("fl_pc", pc_o, 32'h100);

        // flush and hazard together with a valid instruction
        tick(1, 1, 32'h200);
        chk("fh_valid", valid_o, 1'b0);
        chk("fh_instr", instr_o, 32'h0);
        chk("fh_off", pc_offset_o, 12'h0);
        tick();
        chk("fh_addr", imem_addr_o, 32'h200);

        // flush in REQ without grant
        gnt_en = 1'b0;
        tick();
        tick(0, 1, 32'h302);
        gnt_en = 1'b1;
        chk("fr_addr", imem_addr_o, 32'h300);

        // flush coinciding with a live response
        tick();
        tick(0, 1, 32'h400);
        chk("fv_valid", valid_o, 1'b0);
        chk("fv_req", imem_req_o, 1'b1);

        // flush while parked in HOLD
        tick(); tick();
        tick(1); tick(1);
        chk("hold_req", imem_req_o, 1'b0);
        tick(1, 1, 32'h500);
        chk("fhold_req", imem_req_o, 1'b1);
        chk("fhold_addr", imem_addr_o, 32'h500);

        // reset while parked in HOLD
        tick(); tick();
        tick(1); tick(1);
        chk("rh_valid_pre", valid_o, 1'b1);
        RESET = 1'b1;
        tick(1, 1, 32'h600);
        RESET = 1'b0;
        chk("rh_valid", valid_o, 1'b0);
        chk("rh_pc", pc_o, 32'h0);
        chk("rh_instr", instr_o, 32'h0);
        chk("rh_req", imem_req_o, 1'b1);
        chk("rh_addr", imem_addr_o, 32'h0);

        // mixed pattern of stalls, backpressure and redirects
        for (int i = 0; i < 300; i++) begin
            gnt_en = (i % 5) != 3;
            rv_en  = (i % 3) != 1;
            tick((i % 7) < 2, (i % 29) == 13, 32'h1000 + i * 12 + 1);
        end
        gnt_en = 1'b1; rv_en = 1'b1;
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
